panel_key_input: RTL and testbench

- Consumes the debounced front-panel `btn` level produced by the button/debounce stage. Turns each press into one data event carrying the 8-bit switch value.
- Holding the button auto-repeats the event: first after HOLD_CYCLES, then every REPEAT_CYCLES.
- Events go to the CPU input port through a one-entry valid/ready buffer. A sticky overrun flag records any event lost because the buffer was full.

---
 rtl/panel_key_input_pkg.sv | 16 +
 rtl/panel_key_input_hold_timer.sv | 35 +++
 rtl/panel_key_input.sv | 105 ++++++++++
 tb/tb_panel_key_input.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/panel_key_input_pkg.sv
// Shared definitions for the front-panel key input path: FSM encodings and
// default hold/repeat timing derived from the board clock.
package panel_key_input_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHeld   = 2'd1,
    StRepeat = 2'd2
  } key_state_e;

  localparam int unsigned BoardClkHz      = 60_000_000;
  // 100 ms before the first repeat, then 20 ms between repeats
  localparam int unsigned DefHoldCycles   = BoardClkHz / 10;
  localparam int unsigned DefRepeatCycles = BoardClkHz / 50;

endpackage

// File: rtl/panel_key_input_hold_timer.sv
// Hold/repeat interval counter: counts enabled cycles and pulses expire on the
// cycle the count reaches limit, restarting from zero.
module hold_timer #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = enable && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expire) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/panel_key_input.sv
// Front-panel key input: turns button presses (with auto-repeat) into switch
// value events delivered through a one-entry valid/ready buffer.
module panel_key_input
  import panel_key_input_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned HOLD_CYCLES   = DefHoldCycles,
  parameter int unsigned REPEAT_CYCLES = DefRepeatCycles,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             btn,
  input  logic [WIDTH-1:0] sw,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             press,
  output logic             overrun
);

  key_state_e       state_q, state_d;
  logic             btn_q;
  logic             rise;
  logic             evt;
  logic             handshake;
  logic             tmr_clear;
  logic             tmr_expire;
  logic [CNT_W-1:0] tmr_limit;

  assign rise      = btn & ~btn_q;
  assign handshake = rd_valid & rd_ready;

  // Counter only runs while the button is held outside IDLE
  assign tmr_clear = (state_q == StIdle) | ~btn;
  assign tmr_limit = (state_q == StHeld) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(REPEAT_CYCLES - 1);

  hold_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .enable  (~tmr_clear),
    .limit   (tmr_limit),
    .expire  (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    evt     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          evt     = 1'b1;
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (!btn) begin
          state_d = StIdle;
        end else if (tmr_expire) begin
          evt     = 1'b1;
          state_d = StRepeat;
        end
      end
      StRepeat: begin
        if (!btn) begin
          state_d = StIdle;
        end else if (tmr_expire) begin
          evt = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // btn_q resets high so a button held through reset needs a fresh press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      btn_q    <= 1'b1;
      press    <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= btn;
      press   <= evt;
      if (evt) begin
        if (!rd_valid || rd_ready) begin
          rd_data  <= sw;
          rd_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        rd_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_panel_key_input.sv
// Directed self-checking bench for panel_key_input with short hold/repeat timing.
module tb_panel_key_input;
  import panel_key_input_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       btn;
  logic [7:0] sw;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       press;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_press;

  always #5 clk = ~clk;

  panel_key_input #(
    .WIDTH         (8),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .CNT_W         (24)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn      (btn),
    .sw       (sw),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .press    (press),
    .overrun  (overrun)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    btn      = 1'b0;
    sw       = 8'h00;
    rd_ready = 1'b1;
    tick();
    tick();
    chk("rst_press", 32'(press), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    reset_n = 1'b1;
    tick();

    // 1: single short press
    sw  = 8'hA5;
    btn = 1'b1;
    tick();
    chk("t1_press", 32'(press), 32'd1);
    chk("t1_valid", 32'(rd_valid), 32'd1);
    chk("t1_data", 32'(rd_data), 32'hA5);
    tick();
    chk("t1_press_end", 32'(press), 32'd0);
    chk("t1_valid_end", 32'(rd_valid), 32'd0);
    chk("t1_data_hold", 32'(rd_data), 32'hA5);
    tick();
    btn = 1'b0;
    tick();
    chk("t1_no_repeat", 32'(press), 32'd0);

    // 2: held 20 cycles -> events at edges 0, 8, 12, 16
    sw      = 8'h3C;
    btn     = 1'b1;
    n_press = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (press) n_press++;
      chk($sformatf("t2_press_%0d", i), 32'(press),
          32'((i == 0) || (i == 8) || (i == 12) || (i == 16)));
      if (i == 0 || i == 8 || i == 12 || i == 16) chk("t2_data", 32'(rd_data), 32'h3C);
    end
    btn = 1'b0;
    tick();
    chk("t2_count", 32'(n_press), 32'd4);
    chk("t2_state", 32'(dut.state_q), 32'(StIdle));

    // 3: overrun with buffer stalled
    rd_ready = 1'b0;
    sw       = 8'h11;
    btn      = 1'b1;
    tick();
    chk("t3_press1", 32'(press), 32'd1);
    chk("t3_data1", 32'(rd_data), 32'h11);
    chk("t3_ovr1", 32'(overrun), 32'd0);
    btn = 1'b0;
    tick();
    sw  = 8'h22;
    btn = 1'b1;
    tick();
    chk("t3_press2", 32'(press), 32'd1);
    chk("t3_data2", 32'(rd_data), 32'h11);
    chk("t3_valid2", 32'(rd_valid), 32'd1);
    chk("t3_ovr2", 32'(overrun), 32'd1);
    btn      = 1'b0;
    rd_ready = 1'b1;
    tick();
    chk("t3_valid_clr", 32'(rd_valid), 32'd0);
    chk("t3_ovr_clr", 32'(overrun), 32'd0);

    // 4: event coinciding with a handshake
    rd_ready = 1'b0;
    sw       = 8'h55;
    btn      = 1'b1;
    tick();
    chk("t4_data_pre", 32'(rd_data), 32'h55);
    btn = 1'b0;
    tick();
    rd_ready = 1'b1;
    sw       = 8'h7E;
    btn      = 1'b1;
    tick();
    chk("t4_data", 32'(rd_data), 32'h7E);
    chk("t4_valid", 32'(rd_valid), 32'd1);
    chk("t4_ovr", 32'(overrun), 32'd0);
    btn = 1'b0;
    tick();
    chk("t4_valid_end", 32'(rd_valid), 32'd0);

    // 5: reset mid-HELD with button held across release
    sw  = 8'h99;
    btn = 1'b1;
    tick();
    chk("t5_press", 32'(press), 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(rd_valid), 32'd0);
    chk("t5_rst_data", 32'(rd_data), 32'h0);
    chk("t5_rst_state", 32'(dut.state_q), 32'(StIdle));
    chk("t5_rst_cnt", 32'(dut.u_timer.cnt_q), 32'd0);
    tick();
    reset_n = 1'b1;
    n_press = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (press) n_press++;
    end
    chk("t5_held_press", 32'(n_press), 32'd0);
    chk("t5_held_valid", 32'(rd_valid), 32'd0);
    btn = 1'b0;
    tick();
    btn = 1'b1;
    tick();
    chk("t5_repress", 32'(press), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("t5_hold_%0d", i), 32'(press), 32'(i == 8));
    end
    btn = 1'b0;
    tick();

    // 6: release on the edge the hold counter would expire
    btn = 1'b1;
    tick();
    chk("t6_press", 32'(press), 32'd1);
    for (int i = 1; i < 8; i++) tick();
    btn = 1'b0;
    tick();
    chk("t6_no_repeat", 32'(press), 32'd0);
    chk("t6_state", 32'(dut.state_q), 32'(StIdle));
    btn = 1'b1;
    tick();
    chk("t6_repress", 32'(press), 32'd1);
    btn = 1'b0;
    tick();
    chk("t6_ovr", 32'(overrun), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
